// File: rtl/fir_tap_sequencer.sv
// Tap sequencer for a single-MAC FIR engine. It steps the coefficient and
// delay-line select over every tap, then drives MAC enable/clear and a result strobe.
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | waiting for a sample; sample_ready high
// RUN   | coeff_sel walks taps 0..NUM_TAPS-1, one per cycle
// DRAIN | one cycle for the last registered mux product to reach the MAC
// DONE  | accumulator holds the finished sum; result_valid high
module fir_tap_sequencer #(
    parameter int NUM_TAPS = 11,
    parameter int SEL_W    = 4
) (
    input  logic             clk,
    input  logic             GlobalReset,
    input  logic             sample_valid,
    output logic             sample_ready,
    input  logic             flush,
    output logic [SEL_W-1:0] coeff_sel,
    output logic             mac_en,
    output logic             mac_clr,
    output logic             result_valid,
    output logic             busy
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [SEL_W-1:0] LAST_TAP = SEL_W'(NUM_TAPS - 1);

    state_t           state;
    state_t           state_nxt;
    logic [SEL_W-1:0] tap;
    logic [SEL_W-1:0] tap_nxt;

    always_ff @(posedge clk) begin
        if (GlobalReset) begin
            state   <= S_IDLE;
            tap     <= '0;
            mac_en  <= 1'b0;
            mac_clr <= 1'b0;
        end else begin
            state   <= state_nxt;
            tap     <= tap_nxt;
            // delayed one cycle to line up with the registered coefficient mux
            mac_en  <= (state == S_RUN) && !flush;
            mac_clr <= (state == S_RUN) && (tap == '0) && !flush;
        end
    end

    always_comb begin
        state_nxt = state;
        tap_nxt   = tap;
        case (state)
            S_IDLE: begin
                tap_nxt = '0;
                if (sample_valid) begin
                    state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                // >= rather than == keeps a corrupted counter from running past the last tap
                if (tap >= LAST_TAP) begin
                    state_nxt = S_DRAIN;
                    tap_nxt   = '0;
                end else begin
                    tap_nxt = tap + SEL_W'(1);
                end
            end
            S_DRAIN: begin
                state_nxt = S_DONE;
                tap_nxt   = '0;
            end
            S_DONE: begin
                state_nxt = S_IDLE;
                tap_nxt   = '0;
            end
            default: begin
                state_nxt = S_IDLE;
                tap_nxt   = '0;
            end
        endcase
        if (flush) begin
            state_nxt = S_IDLE;
            tap_nxt   = '0;
        end
    end

    assign sample_ready = (state == S_IDLE);
    assign busy         = (state != S_IDLE);
    assign result_valid = (state == S_DONE);
    assign coeff_sel    = (state == S_RUN) ? tap : '0;

endmodule
